// File: rtl/div.sv
// IEEE-754 binary32 divider (restoring, one quotient bit per cycle); DIV_ROUND_NEAREST_EN selects RNE, else truncate.
// Latency: done pulses exactly 28 clk after the accepting edge (unpack + 26 iterations + pack), specials included.
// Backpressure: none; start is ignored while busy, and busy is low in the done cycle so back-to-back starts are taken.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_ITER, S_PACK} state_t;
    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    state_t             state, state_nxt;
    kind_t              kind_q, kind_d;
    logic [31:0]        a_q, b_q;
    logic [4:0]         cnt;
    logic [24:0]        rem;
    logic [23:0]        dvs;
    logic [25:0]        quo;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q;

    // Operand classification; exponent-zero inputs are flushed to zero.
    logic [7:0]  ea, eb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            kind_d = K_NAN;
        else if (a_inf || b_zero)
            kind_d = K_INF;
        else if (a_zero || b_inf)
            kind_d = K_ZERO;
        else
            kind_d = K_NORM;
    end

    // Normalize, round and pack.
    logic [23:0]        mant;
    logic [24:0]        mant_rnd;
    logic               rnd_up;
    logic signed [9:0]  e_norm, e_fin;
    logic [31:0]        packed_res;
`ifdef DIV_ROUND_NEAREST_EN
    logic               guard, sticky;
`endif
    always_comb begin
        if (quo[25]) begin
            mant   = quo[25:2];
            e_norm = exp_q;
        end else begin
            mant   = quo[24:1];
            e_norm = exp_q - 10'sd1;
        end
`ifdef DIV_ROUND_NEAREST_EN
        guard  = quo[25] ? quo[1] : quo[0];
        sticky = (quo[25] & quo[0]) | (|rem);
        rnd_up = guard & (sticky | mant[0]);
`else
        rnd_up = 1'b0;
`endif
        mant_rnd = {1'b0, mant} + {24'd0, rnd_up};
        e_fin    = mant_rnd[24] ? e_norm + 10'sd1 : e_norm;
        case (kind_q)
            K_NAN:   packed_res = 32'h7FC00000;
            K_INF:   packed_res = {sign_q, 8'hFF, 23'd0};
            K_ZERO:  packed_res = {sign_q, 31'd0};
            default: begin
                if (e_fin >= 10'sd255)
                    packed_res = {sign_q, 8'hFF, 23'd0};
                else if (e_fin <= 10'sd0)
                    packed_res = {sign_q, 31'd0};
                else
                    packed_res = {sign_q, e_fin[7:0], mant_rnd[22:0]};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = S_ITER;
            S_ITER:   if (cnt == 5'd25) state_nxt = S_PACK;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    logic [24:0] diff;
    always_comb begin
        diff = rem - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            cnt    <= 5'd0;
            rem    <= 25'd0;
            dvs    <= 24'd0;
            quo    <= 26'd0;
            exp_q  <= 10'sd0;
            sign_q <= 1'b0;
            kind_q <= K_NORM;
            result <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q <= A;
                        b_q <= B;
                    end
                end
                S_UNPACK: begin
                    sign_q <= a_q[31] ^ b_q[31];
                    exp_q  <= exp_d;
                    kind_q <= kind_d;
                    rem    <= {2'b01, a_q[22:0]};
                    dvs    <= {1'b1, b_q[22:0]};
                    quo    <= 26'd0;
                    cnt    <= 5'd0;
                end
                S_ITER: begin
                    // Remainder stays below 2*divisor, so 25 bits suffice after the shift.
                    if (rem >= {1'b0, dvs}) begin
                        rem <= {diff[23:0], 1'b0};
                        quo <= {quo[24:0], 1'b1};
                    end else begin
                        rem <= {rem[23:0], 1'b0};
                        quo <= {quo[24:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                end
                default: begin
                    result <= packed_res;
                    done   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes expected results and due cycles, monitor checks at each done.
module tb_div;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] A, B, result;
    logic        busy, done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];
    int          due_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .result(result), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                logic [31:0] e;
                int          d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("result", result, e);
                check("latency", 32'(cyc), 32'(d));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
        end
    endtask

    // Caller is at a negedge with the DUT idle (or in its done cycle).
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input bit push, input logic [31:0] expv);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (push) begin
            exp_q.push_back(expv);
            due_q.push_back(cyc + 28);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        wait_idle();
        drive(a, b, 1'b1, expv);
    endtask

    logic [31:0] vec_a[14] = '{32'h3F800000, 32'h3F800000, 32'hBFA00000, 32'h42FE1000,
                               32'h3F800000, 32'h00000000, 32'h7F000000, 32'h7F800000,
                               32'h80000000, 32'h7FC00001, 32'h00000001, 32'h3F800000,
                               32'h00800000, 32'h7F800000};
    logic [31:0] vec_b[14] = '{32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'h41878000,
                               32'h00000000, 32'h00000000, 32'h00800000, 32'hC0000000,
                               32'h40400000, 32'h3F800000, 32'hBF800000, 32'h00000010,
                               32'h7F000000, 32'h7F800000};
`ifdef DIV_ROUND_NEAREST_EN
    localparam logic [31:0] TWO_THIRDS = 32'h3F2AAAAB;
`else
    localparam logic [31:0] TWO_THIRDS = 32'h3F2AAAAA;
`endif
    logic [31:0] vec_r[14] = '{32'h3F800000, TWO_THIRDS, 32'hBF555555, 32'h40F00000,
                               32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'hFF800000,
                               32'h80000000, 32'h7FC00000, 32'h80000000, 32'h7F800000,
                               32'h00000000, 32'h7FC00000};

    initial begin
        rst = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run(vec_a[i], vec_b[i], vec_r[i]);
            if (i == 0) check("busy_after_start", {31'd0, busy}, 32'd1);
        end
        wait_idle();

        // 6.0 / 2.0 = 3.0, then check it is held while idle.
        run(32'h40C00000, 32'h40000000, 32'h40400000);
        wait_idle();
        repeat (5) @(negedge clk);
        check("result_held", result, 32'h40400000);

        // Start while busy must be ignored (would give 1.0 if taken).
        run(32'h42FE1000, 32'h41878000, 32'h40F00000);
        repeat (5) @(negedge clk);
        drive(32'h3F800000, 32'h3F800000, 1'b0, 32'h0);
        wait_idle();

        // Back-to-back: new start issued in the done cycle.
        run(32'h3F800000, 32'h3FC00000, TWO_THIRDS);
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_seen", {31'd0, done}, 32'd1);
        end
        check("b2b_busy_in_done", {31'd0, busy}, 32'd0);
        drive(32'hBFA00000, 32'h3FC00000, 1'b1, 32'hBF555555);
        wait_idle();
        repeat (2) @(negedge clk);

        // Reset at cycle 10 of an operation: aborted, no done.
        drive(32'h40C00000, 32'h40000000, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_result", result, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (35) @(negedge clk);

        // Start together with reset is ignored.
        rst = 1'b1;
        drive(32'h3F800000, 32'h3F800000, 1'b0, 32'h0);
        rst = 1'b0;
        check("start_with_rst_busy", {31'd0, busy}, 32'd0);
        repeat (35) @(negedge clk);
        check("start_with_rst_result", result, 32'h0);

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 No parameters; operand and result width fixed at 32 bits (IEEE-754 binary32).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request pulse; sampled only while busy=0.
REQ-006 A  input  32  dividend, binary32; captured on accepted start.
REQ-007 B  input  32  divisor, binary32; captured on accepted start.
REQ-008 result  output  32  quotient A/B, binary32; held until next completion.
REQ-009 busy  output  1  high from the cycle after accepted start until done.
REQ-010 done  output  1  one-cycle pulse; result valid in the same cycle.

Function
REQ-011 start with busy=0 SHALL latch A, B and set busy next cycle; start while busy=1 SHALL be ignored.
REQ-012 Fixed latency: done SHALL pulse exactly 28 clk cycles after the accepting edge, special cases included.
REQ-013 Pipeline: 1 unpack cycle, 26 restoring-division iterations (one quotient bit each), 1 normalize/round/pack cycle.
REQ-014 Sign SHALL be A[31] XOR B[31] for every result except NaN.
REQ-015 Exponent SHALL be expA - expB + 127, with 10-bit signed intermediate arithmetic.
REQ-016 Mantissas SHALL carry the implicit 1 (24 bits); quotient SHALL be 1.x or 0.1x; 0.1x SHALL be shifted left 1 with exponent decremented.
REQ-017 Rounding per Configuration; mantissa carry-out from rounding SHALL increment the exponent.
REQ-018 Denormal operands SHALL be treated as signed zero (flush-to-zero).
REQ-019 Final exponent >= 255 SHALL give signed infinity.
REQ-020 Final exponent <= 0 SHALL give signed zero.
REQ-021 Any NaN operand, 0/0 or Inf/Inf SHALL give 0x7FC00000.
REQ-022 Finite nonzero / 0 and Inf / finite SHALL give signed infinity.
REQ-023 0 / nonzero finite and finite / Inf SHALL give signed zero.
REQ-024 result SHALL change only in the done cycle or at reset.
REQ-025 start and done in the same cycle: the new start SHALL be accepted, since busy is 0 in the done cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL clear result to 0x00000000, busy to 0, done to 0 and all iteration state.
REQ-027 Reset mid-operation SHALL abort the division with no done pulse.
REQ-028 start asserted together with rst SHALL be ignored.

Configuration
REQ-029 Macro DIV_ROUND_NEAREST_EN defined: round-to-nearest-even using the guard bit plus a sticky bit (nonzero remainder OR the extra quotient bit).
REQ-030 Macro DIV_ROUND_NEAREST_EN undefined: truncation toward zero; guard and sticky are discarded. Latency and special-case handling are the same in both builds.

Verification
REQ-031 A=0x3F800000, B=0x3F800000 -> result 0x3F800000 (1.0) at done, 28 cycles after start.
REQ-032 A=0x3F800000, B=0x3FC00000 -> result 0x3F2AAAAB with macro defined, 0x3F2AAAAA without (0.66667).
REQ-033 A=0xBFA00000, B=0x3FC00000 -> result 0xBF555555 (-0.83333) in both builds.
REQ-034 A=0x42FE1000, B=0x41878000 -> result 0x40F00000 (7.5 exact).
REQ-035 Special cases:
- A=0x3F800000, B=0x00000000 -> 0x7F800000.
- A=0, B=0 -> 0x7FC00000.
- A=0x7F000000, B=0x00800000 -> 0x7F800000 (overflow).
REQ-036 Control timing:
- start re-asserted while busy -> ignored.
- rst at cycle 10 of an operation -> no done pulse, result=0.
- Back-to-back start in the done cycle -> second result after 28 more cycles.
